// File: rtl/pifo_sorted_reg_pkg.sv
// rtl/pifo_sorted_reg_pkg.sv - shared types and helpers for the sorted register PIFO
// Contents: dequeue-order encoding, per-slot select encoding, clog2 helper for the count width.
package pifo_sorted_reg_pkg;

    typedef enum logic {
        ORD_MIN = 1'b0,
        ORD_MAX = 1'b1
    } order_t;

    // What a slot loads on the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_NEW   = 2'd1,
        SEL_LOWER = 2'd2,   // take slot i-1 (shift up, making room for an insert)
        SEL_UPPER = 2'd3    // take slot i+1 (shift down, after a pop)
    } sel_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/pifo_sorted_reg_if.sv
// rtl/pifo_sorted_reg_if.sv - insert/head/evict handshake bundle of the sorted PIFO
// Signals: in_valid/in_ready/in_rank/in_meta (insert), out_valid/out_ready/out_rank/out_meta (head),
//          evict_valid/evict_rank/evict_meta (dropped entry). slave = queue side, master = user side.
interface pifo_sorted_reg_if #(
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [RANK_WIDTH-1:0] in_rank;
    logic [META_WIDTH-1:0] in_meta;
    logic                  out_valid;
    logic                  out_ready;
    logic [RANK_WIDTH-1:0] out_rank;
    logic [META_WIDTH-1:0] out_meta;
    logic                  evict_valid;
    logic [RANK_WIDTH-1:0] evict_rank;
    logic [META_WIDTH-1:0] evict_meta;

    modport slave (
        input  in_valid, in_rank, in_meta, out_ready,
        output in_ready, out_valid, out_rank, out_meta,
        output evict_valid, evict_rank, evict_meta
    );

    modport master (
        output in_valid, in_rank, in_meta, out_ready,
        input  in_ready, out_valid, out_rank, out_meta,
        input  evict_valid, evict_rank, evict_meta
    );
endinterface

// File: rtl/pifo_sorted_cell.sv
// rtl/pifo_sorted_cell.sv - one slot of the sorted PIFO
// Ports: clk, rst_n, sel (hold/new/lower/upper), new_rank/new_meta, lower_* and upper_* neighbour
//        contents, valid/rank/meta (slot contents), prec_eq (slot precedes-or-equals new_rank).
module pifo_sorted_cell
    import pifo_sorted_reg_pkg::*;
#(
    parameter int     RANK_WIDTH = 16,
    parameter int     META_WIDTH = 32,
    parameter order_t ORDER      = ORD_MIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  sel_t                  sel,
    input  logic [RANK_WIDTH-1:0] new_rank,
    input  logic [META_WIDTH-1:0] new_meta,
    input  logic                  lower_valid,
    input  logic [RANK_WIDTH-1:0] lower_rank,
    input  logic [META_WIDTH-1:0] lower_meta,
    input  logic                  upper_valid,
    input  logic [RANK_WIDTH-1:0] upper_rank,
    input  logic [META_WIDTH-1:0] upper_meta,
    output logic                  valid,
    output logic [RANK_WIDTH-1:0] rank,
    output logic [META_WIDTH-1:0] meta,
    output logic                  prec_eq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            rank  <= '0;
            meta  <= '0;
        end else begin
            case (sel)
                SEL_NEW: begin
                    valid <= 1'b1;
                    rank  <= new_rank;
                    meta  <= new_meta;
                end
                SEL_LOWER: begin
                    valid <= lower_valid;
                    rank  <= lower_rank;
                    meta  <= lower_meta;
                end
                SEL_UPPER: begin
                    valid <= upper_valid;
                    rank  <= upper_rank;
                    meta  <= upper_meta;
                end
                default: ;
            endcase
        end
    end

    // "Or-equal" puts a newcomer behind existing equal ranks, giving the FIFO tie-break.
    assign prec_eq = valid && ((ORDER == ORD_MIN) ? (rank <= new_rank) : (rank >= new_rank));

endmodule

// File: rtl/pifo_sorted_reg.sv
// rtl/pifo_sorted_reg.sv - register-based PIFO kept sorted on insert, head always in slot 0
// Ports: clk, rst_n (async active-low), bus (pifo_sorted_reg_if.slave: insert, head, evict),
//        count (occupancy), full (count == DEPTH).
module pifo_sorted_reg
    import pifo_sorted_reg_pkg::*;
#(
    parameter int     DEPTH      = 8,
    parameter int     RANK_WIDTH = 16,
    parameter int     META_WIDTH = 32,
    parameter order_t ORDER      = ORD_MIN,
    parameter bit     EVICT      = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pifo_sorted_reg_if.slave            bus,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        full
);

    localparam int CW = clog2(DEPTH + 1);

    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0]      slot_prec;
    logic [RANK_WIDTH-1:0] slot_rank [DEPTH];
    logic [META_WIDTH-1:0] slot_meta [DEPTH];
    sel_t                  sel       [DEPTH];

    logic [CW-1:0]         ins_pos;
    logic [CW-1:0]         ins_pos_pop;
    logic                  push;
    logic                  pop;
    logic                  evict_new;
    logic                  evict_now;
    logic                  evict_valid_q;
    logic [RANK_WIDTH-1:0] evict_rank_q;
    logic [META_WIDTH-1:0] evict_meta_q;

    assign full      = (count == CW'(DEPTH));
    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready = EVICT ? 1'b1 : ~full;
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = slot_valid[0] && bus.out_ready;

    assign bus.out_valid   = slot_valid[0];
    assign bus.out_rank    = slot_rank[0];
    assign bus.out_meta    = slot_meta[0];
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_rank  = evict_rank_q;
    assign bus.evict_meta  = evict_meta_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic                  lower_valid;
        logic [RANK_WIDTH-1:0] lower_rank;
        logic [META_WIDTH-1:0] lower_meta;
        logic                  upper_valid;
        logic [RANK_WIDTH-1:0] upper_rank;
        logic [META_WIDTH-1:0] upper_meta;

        if (i == 0) begin : g_bottom
            assign lower_valid = 1'b0;
            assign lower_rank  = '0;
            assign lower_meta  = '0;
        end else begin : g_lower
            assign lower_valid = slot_valid[i-1];
            assign lower_rank  = slot_rank[i-1];
            assign lower_meta  = slot_meta[i-1];
        end

        // The top slot shifts in zeros so a vacated slot reads as empty and cleared.
        if (i == DEPTH - 1) begin : g_top
            assign upper_valid = 1'b0;
            assign upper_rank  = '0;
            assign upper_meta  = '0;
        end else begin : g_upper
            assign upper_valid = slot_valid[i+1];
            assign upper_rank  = slot_rank[i+1];
            assign upper_meta  = slot_meta[i+1];
        end

        pifo_sorted_cell #(
            .RANK_WIDTH (RANK_WIDTH),
            .META_WIDTH (META_WIDTH),
            .ORDER      (ORDER)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .sel         (sel[i]),
            .new_rank    (bus.in_rank),
            .new_meta    (bus.in_meta),
            .lower_valid (lower_valid),
            .lower_rank  (lower_rank),
            .lower_meta  (lower_meta),
            .upper_valid (upper_valid),
            .upper_rank  (upper_rank),
            .upper_meta  (upper_meta),
            .valid       (slot_valid[i]),
            .rank        (slot_rank[i]),
            .meta        (slot_meta[i]),
            .prec_eq     (slot_prec[i])
        );
    end

    // The sort invariant makes slot_prec a thermometer, so the highest set bit gives p.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_prec[i]) begin
                ins_pos = CW'(i + 1);
            end
        end
    end

    // With a simultaneous pop every survivor moves down one, so the insert lands one lower.
    assign ins_pos_pop = (ins_pos == '0) ? '0 : ins_pos - CW'(1);
    // Full and nothing in the queue is worse than the newcomer: the newcomer is dropped.
    assign evict_new   = (ins_pos == CW'(DEPTH));
    assign evict_now   = push && !pop && full;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (push && pop) begin
                if (CW'(i) < ins_pos_pop) begin
                    sel[i] = SEL_UPPER;
                end else if (CW'(i) == ins_pos_pop) begin
                    sel[i] = SEL_NEW;
                end
            end else if (push) begin
                if (!(full && evict_new)) begin
                    if (CW'(i) == ins_pos) begin
                        sel[i] = SEL_NEW;
                    end else if (CW'(i) > ins_pos) begin
                        sel[i] = SEL_LOWER;
                    end
                end
            end else if (pop) begin
                sel[i] = SEL_UPPER;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop && !full) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evict_valid_q <= 1'b0;
            evict_rank_q  <= '0;
            evict_meta_q  <= '0;
        end else begin
            evict_valid_q <= evict_now;
            if (evict_now) begin
                if (evict_new) begin
                    evict_rank_q <= bus.in_rank;
                    evict_meta_q <= bus.in_meta;
                end else begin
                    evict_rank_q <= slot_rank[DEPTH-1];
                    evict_meta_q <= slot_meta[DEPTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pifo_sorted_reg.sv
// tb/tb_pifo_sorted_reg.sv - scoreboard bench for pifo_sorted_reg in four configurations
module tb_pifo_sorted_reg;
    import pifo_sorted_reg_pkg::*;

    typedef logic [47:0] ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic        in_valid    [4];
    logic [15:0] in_rank     [4];
    logic [31:0] in_meta     [4];
    logic        out_ready   [4];
    logic        in_ready    [4];
    logic        out_valid   [4];
    logic [15:0] out_rank    [4];
    logic [31:0] out_meta    [4];
    logic        evict_valid [4];
    logic [15:0] evict_rank  [4];
    logic [31:0] evict_meta  [4];
    logic        full        [4];
    logic [3:0]  cnt         [4];
    logic [3:0]  cnt0;
    logic [2:0]  cnt1, cnt2, cnt3;

    ent_t exp_pop [4][$];
    ent_t exp_ev  [4][$];
    ent_t model [$];

    pifo_sorted_reg_if bus [4] ();

    for (genvar k = 0; k < 4; k++) begin : g_io
        assign bus[k].in_valid  = in_valid[k];
        assign bus[k].in_rank   = in_rank[k];
        assign bus[k].in_meta   = in_meta[k];
        assign bus[k].out_ready = out_ready[k];
        assign in_ready[k]      = bus[k].in_ready;
        assign out_valid[k]     = bus[k].out_valid;
        assign out_rank[k]      = bus[k].out_rank;
        assign out_meta[k]      = bus[k].out_meta;
        assign evict_valid[k]   = bus[k].evict_valid;
        assign evict_rank[k]    = bus[k].evict_rank;
        assign evict_meta[k]    = bus[k].evict_meta;
    end

    assign cnt[0] = cnt0;
    assign cnt[1] = {1'b0, cnt1};
    assign cnt[2] = {1'b0, cnt2};
    assign cnt[3] = {1'b0, cnt3};

    pifo_sorted_reg #(.DEPTH(8), .ORDER(ORD_MIN), .EVICT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus[0]), .count(cnt0), .full(full[0]));
    pifo_sorted_reg #(.DEPTH(4), .ORDER(ORD_MIN), .EVICT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus[1]), .count(cnt1), .full(full[1]));
    pifo_sorted_reg #(.DEPTH(4), .ORDER(ORD_MIN), .EVICT(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus[2]), .count(cnt2), .full(full[2]));
    pifo_sorted_reg #(.DEPTH(5), .ORDER(ORD_MAX), .EVICT(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus[3]), .count(cnt3), .full(full[3]));

    function automatic ent_t e(input int r, input int m);
        return {16'(r), 32'(m)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input int k, input bit push, input logic [15:0] r,
                        input logic [31:0] m, input bit pop);
        in_valid[k]  = push;
        in_rank[k]   = r;
        in_meta[k]   = m;
        out_ready[k] = pop;
        @(posedge clk);
        #1;
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
    endtask

    // Behavioural model for the ORD_MAX/DEPTH=5/EVICT=1 queue: pop first, insert behind
    // equal ranks, and drop whatever ends up last if the list overflows.
    task automatic rnd_step(input bit push, input logic [15:0] r, input logic [31:0] m, input bit pop);
        int pos;
        if (pop && model.size() > 0) begin
            exp_pop[3].push_back(model.pop_front());
        end
        if (push) begin
            pos = 0;
            foreach (model[i]) begin
                if (model[i][47:32] >= r) pos = i + 1;
            end
            model.insert(pos, {r, m});
            if (model.size() > 5) begin
                exp_ev[3].push_back(model.pop_back());
            end
        end
        step(3, push, r, m, pop);
        check("count dut3", 64'(cnt[3]), 64'(model.size()));
    endtask

    // Monitor: compares every head handshake and every evict pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_pop[k].size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL pop_unexpected dut%0d: got rank %0d meta %0h, required no pop",
                                 k, out_rank[k], out_meta[k]);
                    end else begin
                        check($sformatf("pop dut%0d", k), 64'({out_rank[k], out_meta[k]}),
                              64'(exp_pop[k].pop_front()));
                    end
                end
                if (evict_valid[k]) begin
                    if (exp_ev[k].size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL evict_unexpected dut%0d: got rank %0d meta %0h, required no evict",
                                 k, evict_rank[k], evict_meta[k]);
                    end else begin
                        check($sformatf("evict dut%0d", k), 64'({evict_rank[k], evict_meta[k]}),
                              64'(exp_ev[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_rank[k]   = '0;
            in_meta[k]   = '0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset count dut%0d", k), 64'(cnt[k]), 64'd0);
            check($sformatf("reset out_valid dut%0d", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("reset full dut%0d", k), 64'(full[k]), 64'd0);
            check($sformatf("reset evict_valid dut%0d", k), 64'(evict_valid[k]), 64'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("idle in_ready dut%0d", k), 64'(in_ready[k]), 64'd1);
        end

        // Reset mid-stream after three inserts.
        step(0, 1, 16'd5, 32'h1, 0);
        step(0, 1, 16'd6, 32'h2, 0);
        step(0, 1, 16'd7, 32'h3, 0);
        check("count before reset", 64'(cnt[0]), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset count", 64'(cnt[0]), 64'd0);
        check("async reset out_valid", 64'(out_valid[0]), 64'd0);
        check("async reset out_rank", 64'(out_rank[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post reset out_rank", 64'(out_rank[0]), 64'd0);
        check("post reset count", 64'(cnt[0]), 64'd0);
        check("post reset out_valid", 64'(out_valid[0]), 64'd0);

        // ORD_MIN ordering with FIFO tie-break.
        step(0, 1, 16'd5, 32'hA, 0);
        step(0, 1, 16'd2, 32'hB, 0);
        step(0, 1, 16'd9, 32'hC, 0);
        step(0, 1, 16'd2, 32'hD, 0);
        check("count after 4 pushes", 64'(cnt[0]), 64'd4);
        exp_pop[0].push_back(e(2, 'hB));
        step(0, 0, 0, 0, 1);
        check("count pop1", 64'(cnt[0]), 64'd3);
        exp_pop[0].push_back(e(2, 'hD));
        step(0, 0, 0, 0, 1);
        check("count pop2", 64'(cnt[0]), 64'd2);
        exp_pop[0].push_back(e(5, 'hA));
        step(0, 0, 0, 0, 1);
        check("count pop3", 64'(cnt[0]), 64'd1);
        exp_pop[0].push_back(e(9, 'hC));
        step(0, 0, 0, 0, 1);
        check("count pop4", 64'(cnt[0]), 64'd0);

        // Simultaneous push and pop.
        step(0, 1, 16'd3, 32'h30, 0);
        step(0, 1, 16'd7, 32'h70, 0);
        exp_pop[0].push_back(e(3, 'h30));
        step(0, 1, 16'd1, 32'h10, 1);
        check("count push+pop 1", 64'(cnt[0]), 64'd2);
        exp_pop[0].push_back(e(1, 'h10));
        step(0, 1, 16'd8, 32'h80, 1);
        check("count push+pop 2", 64'(cnt[0]), 64'd2);
        exp_pop[0].push_back(e(7, 'h70));
        step(0, 0, 0, 0, 1);
        exp_pop[0].push_back(e(8, 'h80));
        step(0, 0, 0, 0, 1);
        check("count drained dut0", 64'(cnt[0]), 64'd0);

        // Backpressure when full (EVICT=0, DEPTH=4).
        step(1, 1, 16'd3, 32'h43, 0);
        step(1, 1, 16'd1, 32'h41, 0);
        step(1, 1, 16'd4, 32'h44, 0);
        step(1, 1, 16'd2, 32'h42, 0);
        check("full dut1", 64'(full[1]), 64'd1);
        check("in_ready full dut1", 64'(in_ready[1]), 64'd0);
        step(1, 1, 16'd0, 32'h40, 0);
        check("count refused push", 64'(cnt[1]), 64'd4);
        exp_pop[1].push_back(e(1, 'h41));
        step(1, 1, 16'd0, 32'h40, 1);
        check("count refused push+pop", 64'(cnt[1]), 64'd3);
        check("in_ready after pop dut1", 64'(in_ready[1]), 64'd1);
        exp_pop[1].push_back(e(2, 'h42));
        step(1, 0, 0, 0, 1);
        exp_pop[1].push_back(e(3, 'h43));
        step(1, 0, 0, 0, 1);
        exp_pop[1].push_back(e(4, 'h44));
        step(1, 0, 0, 0, 1);
        check("count drained dut1", 64'(cnt[1]), 64'd0);

        // Evict on full (EVICT=1, DEPTH=4).
        step(2, 1, 16'd1, 32'h51, 0);
        step(2, 1, 16'd2, 32'h52, 0);
        step(2, 1, 16'd3, 32'h53, 0);
        step(2, 1, 16'd4, 32'h54, 0);
        check("full dut2", 64'(full[2]), 64'd1);
        check("in_ready full dut2", 64'(in_ready[2]), 64'd1);
        exp_ev[2].push_back(e(4, 'h54));
        step(2, 1, 16'd2, 32'h55, 0);
        check("count evict old", 64'(cnt[2]), 64'd4);
        exp_ev[2].push_back(e(9, 'h59));
        step(2, 1, 16'd9, 32'h59, 0);
        check("count evict new", 64'(cnt[2]), 64'd4);
        exp_pop[2].push_back(e(1, 'h51));
        step(2, 0, 0, 0, 1);
        exp_pop[2].push_back(e(2, 'h52));
        step(2, 0, 0, 0, 1);
        exp_pop[2].push_back(e(2, 'h55));
        step(2, 0, 0, 0, 1);
        exp_pop[2].push_back(e(3, 'h53));
        step(2, 0, 0, 0, 1);
        check("count drained dut2", 64'(cnt[2]), 64'd0);

        // ORD_MAX random traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            rnd_step(($urandom_range(0, 9) < 6), 16'($urandom_range(0, 7)), 32'(n),
                     1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 6; n++) begin
            rnd_step(1'b0, 16'd0, 32'd0, 1'b1);
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pending pops dut%0d", k), 64'(exp_pop[k].size()), 64'd0);
            check($sformatf("pending evicts dut%0d", k), 64'(exp_ev[k].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
